// File: rtl/muldiv_pkg.sv
// Shared decoder types for the execute stage.
// alu_op_e carries every ALU/M-extension operation select.
package muldiv_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULSU, ALU_MULU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One bit per cycle on magnitudes, with sign fix-up on the last iteration.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  alu_op_e         alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e          r_state;
    state_e          w_next;
    alu_op_e         r_op;
    logic [5:0]      r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic            r_neg;
    logic            r_rneg;

    logic            w_valid;
    logic            w_is_div;
    logic            w_sa;
    logic            w_sb;
    logic            w_div0;
    logic            w_ovf;
    logic            w_fast;
    logic            w_accept;
    logic            w_last;
    logic            w_calc_div;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_hi_n;
    logic [XLEN-1:0] w_lo_n;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0] w_final;

    assign w_valid  = alu_op inside {ALU_MUL, ALU_MULH, ALU_MULSU, ALU_MULU,
                                     ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign w_is_div = alu_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign w_sa     = op_a[XLEN-1] &&
                      (alu_op inside {ALU_MULH, ALU_MULSU, ALU_DIV, ALU_REM});
    assign w_sb     = op_b[XLEN-1] &&
                      (alu_op inside {ALU_MULH, ALU_DIV, ALU_REM});
    assign w_div0   = w_is_div && (op_b == '0);
    assign w_ovf    = (alu_op inside {ALU_DIV, ALU_REM}) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
    assign w_fast   = w_div0 || w_ovf;
    assign w_accept = (r_state == S_IDLE) && start && w_valid && !kill;
    assign w_last   = (r_state == S_CALC) && (r_cnt == 6'(XLEN - 1));

    // One shift-add (multiply) or restoring-subtract (divide) step.
    assign w_calc_div = r_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_ge    = !w_diff[XLEN];

    always_comb begin
        if (w_calc_div) begin
            w_hi_n = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            w_lo_n = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_n = w_sum[XLEN:1];
            w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    assign w_prod   = {w_hi_n, w_lo_n};
    assign w_prod_s = r_neg ? -w_prod : w_prod;

    always_comb begin
        w_final = '0;
        unique case (r_op)
            ALU_MUL:                       w_final = w_prod_s[XLEN-1:0];
            ALU_MULH, ALU_MULSU, ALU_MULU: w_final = w_prod_s[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:             w_final = r_neg ? -w_lo_n : w_lo_n;
            ALU_REM, ALU_REMU:             w_final = r_rneg ? -w_hi_n : w_hi_n;
            default:                       w_final = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (kill) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (start && w_valid)
                             w_next = w_fast ? S_DONE : S_CALC;
                S_CALC:  if (w_last) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    assign result = r_result;

    // Multiplier and dividend share r_lo; multiplicand and divisor share r_b.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= ALU_ADD;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op   <= alu_op;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= w_sa ? -op_a : op_a;
            r_b    <= w_sb ? -op_b : op_b;
            r_neg  <= w_sa ^ w_sb;
            r_rneg <= w_sa;
            if (w_div0)
                r_result <= (alu_op inside {ALU_DIV, ALU_DIVU}) ? '1 : op_a;
            else if (w_ovf)
                r_result <= (alu_op == ALU_DIV) ? op_a : '0;
        end else if (r_state == S_CALC && !kill) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) r_result <= w_final;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed table, random ops vs. arithmetic model,
// and kill / reset / ignored-start sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    alu_op_e     alu_op = ALU_ADD;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
        .op_a(op_a), .op_b(op_b), .kill(kill),
        .busy(busy), .done(done), .result(result)
    );

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(alu_op_e op, logic [31:0] a,
                                          logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            ALU_MUL:   begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            ALU_MULH:  begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
            ALU_MULSU: begin
                sp = longint'(sa) * longint'({32'b0, b});
                return sp[63:32];
            end
            ALU_MULU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            ALU_DIV:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            ALU_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:   return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            ALU_REMU:  return (b == 0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic dv;
        dv = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        if (dv && b == 0) return 1;
        if ((op inside {ALU_DIV, ALU_REM}) && a == 32'h8000_0000 &&
            b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic void add(alu_op_e op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] e, int l);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = e; v.lat = l;
        tbl.push_back(v);
    endfunction

    // Called #1 after an edge with the unit idle; returns in the done cycle.
    task automatic run_op(input alu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output int busy_low);
        alu_op = op; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_low = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_low++;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy) busy_low++;
        res = result;
    endtask

    task automatic after_done(input string tag, input logic [31:0] exp);
        @(posedge clk); #1;
        check({tag, "_done_low"}, {31'b0, done}, 32'd0);
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        logic [31:0] res, a, b, e;
        int          lat, bl, cnt, pulses;
        alu_op_e     op;
        alu_op_e     ops[8];
        string       nm;

        ops = '{ALU_MUL, ALU_MULH, ALU_MULSU, ALU_MULU,
                ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

        add(ALU_MUL,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        add(ALU_MULH,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        add(ALU_MULU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        add(ALU_MULSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        add(ALU_MUL,   32'd0,          32'h0001_2345, 32'd0,         33);
        add(ALU_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        add(ALU_REM,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        add(ALU_DIVU,  32'd100,        32'd7,         32'd14,        33);
        add(ALU_REMU,  32'd100,        32'd7,         32'd2,         33);
        add(ALU_DIVU,  32'd3,          32'd5,         32'd0,         33);
        add(ALU_DIVU,  32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33);
        add(ALU_REM,   32'h8000_0000,  32'd3,         32'hFFFF_FFFE, 33);
        add(ALU_DIVU,  32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        add(ALU_REM,   32'd5,          32'd0,         32'd5,         1);
        add(ALU_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        add(ALU_REM,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            nm = $sformatf("vec%0d_%s", i, tbl[i].op.name());
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, bl);
            check({nm, "_result"}, res, tbl[i].exp);
            check({nm, "_latency"}, 32'(lat), 32'(tbl[i].lat));
            check({nm, "_busy_gaps"}, 32'(bl), 32'd0);
            after_done(nm, tbl[i].exp);
        end

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 7)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = -($urandom_range(1, 1000));
                default: ;
            endcase
            e = model(op, a, b);
            nm = $sformatf("rnd%0d_%s", i, op.name());
            run_op(op, a, b, res, lat, bl);
            check({nm, "_result"}, res, e);
            check({nm, "_latency"}, 32'(lat), 32'(model_lat(op, a, b)));
            @(posedge clk); #1;
        end

        // start during CALC must not disturb the running divide
        alu_op = ALU_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        alu_op = ALU_MUL; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 6;
        while (!done && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("ignored_start_result", result, 32'd14);
        check("ignored_start_latency", 32'(cnt), 32'd33);
        @(posedge clk); #1;

        // kill at cycle 10 of a divide
        alu_op = ALU_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int c = 1; c < 10; c++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", {31'b0, busy}, 32'd0);
        check("kill_done", {31'b0, done}, 32'd0);
        check("kill_no_pulse", 32'(pulses), 32'd0);
        check("kill_result_kept", result, 32'd14);
        @(posedge clk); #1;
        run_op(ALU_DIV, 32'd1000, 32'd3, res, lat, bl);
        check("post_kill_result", res, 32'd333);
        check("post_kill_latency", 32'(lat), 32'd33);
        after_done("post_kill", 32'd333);

        // kill beats start in IDLE
        alu_op = ALU_DIVU; op_a = 32'd9; op_b = 32'd3; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill_vs_start_busy", {31'b0, busy}, 32'd0);

        // kill in DONE: pulse already visible, result kept
        run_op(ALU_MULU, 32'h0001_0000, 32'h0001_0000, res, lat, bl);
        check("kill_done_result", res, 32'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_done_busy", {31'b0, busy}, 32'd0);
        check("kill_done_hold", result, 32'd1);

        // reset mid-multiply at cycle 20
        alu_op = ALU_MUL; op_a = 32'd7; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        pulses = 0;
        alu_op = ALU_ADD; op_a = 32'd1; op_b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("add_ignored_busy", {31'b0, busy}, 32'd0);
        for (int c = 0; c < 40; c++) begin
            if (done || busy) pulses++;
            @(posedge clk); #1;
        end
        check("add_ignored_activity", 32'(pulses), 32'd0);
        check("add_ignored_result", result, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
